// File: rtl/ifetch_queue.sv
// Instruction-fetch queue: issues sequential fetches, tags returned words with their PC
// and presents them in order to decode. Optional misaligned-redirect halt: FETCH_ALIGN_CHECK_EN.
module ifetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  output logic        inst_misaligned
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam logic [PW:0] DEPTH_L = (PW+1)'(DEPTH);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic {ST_RUN, ST_HALT} state_t;

  state_t        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [PW-1:0] alloc_q, alloc_d, fill_q, fill_d, rd_q, rd_d, discard_q, discard_d;
  logic [31:0]   pc_mem   [DEPTH];
  logic [31:0]   data_mem [DEPTH];

  logic [31:0]   redir_pc;
  logic          redir_mis;
  logic [PW-1:0] inflight, used;
  logic [PW:0]   credit_sum;
  logic          halted, head_valid, req_fire, rsp_drop, rsp_wr, pop;

`ifdef FETCH_ALIGN_CHECK_EN
  assign redir_pc  = redirect_pc;
  assign redir_mis = |redirect_pc[1:0];
`else
  assign redir_pc  = redirect_pc & ~32'h3;
  assign redir_mis = 1'b0;
`endif

  assign inflight   = alloc_q - fill_q;
  assign used       = alloc_q - rd_q;
  // Stale responses still hold credit so every returning word has a slot.
  assign credit_sum = {1'b0, used} + {1'b0, discard_q};
  assign halted     = (state_q == ST_HALT);
  assign head_valid = (fill_q != rd_q);

  assign imem_req_valid  = reset & ~halted & (credit_sum < DEPTH_L);
  assign imem_req_addr   = fetch_pc_q;
  assign req_fire        = imem_req_valid & imem_req_ready;
  assign rsp_drop        = imem_rsp_valid & (discard_q != '0);
  assign rsp_wr          = imem_rsp_valid & (discard_q == '0) & (inflight != '0);
  assign pop             = reset & ~halted & head_valid & inst_ready;

  assign inst_valid      = reset & (halted | head_valid);
  assign inst_data       = halted ? NOP : data_mem[rd_q[AW-1:0]];
  assign inst_pc         = halted ? fetch_pc_q : pc_mem[rd_q[AW-1:0]];
  assign inst_misaligned = reset & halted;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    alloc_d    = alloc_q;
    fill_d     = fill_q;
    rd_d       = rd_q;
    discard_d  = discard_q;
    if (redirect) begin
      fetch_pc_d = redir_pc;
      fill_d     = alloc_q;
      rd_d       = alloc_q;
      // Outstanding requests, plus one accepted now, become stale; a word accepted now is not.
      discard_d  = discard_q + inflight + PW'(req_fire) - PW'(rsp_drop | rsp_wr);
      state_d    = redir_mis ? ST_HALT : ST_RUN;
    end else begin
      if (req_fire) begin
        alloc_d    = alloc_q + PW'(1);
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (rsp_wr)   fill_d    = fill_q + PW'(1);
      if (rsp_drop) discard_d = discard_q - PW'(1);
      if (pop)      rd_d      = rd_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_RUN;
      fetch_pc_q <= RESET_PC;
      alloc_q    <= '0;
      fill_q     <= '0;
      rd_q       <= '0;
      discard_q  <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      alloc_q    <= alloc_d;
      fill_q     <= fill_d;
      rd_q       <= rd_d;
      discard_q  <= discard_d;
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire) pc_mem[alloc_q[AW-1:0]]  <= fetch_pc_q;
    if (reset && rsp_wr) data_mem[fill_q[AW-1:0]] <= imem_rsp_data;
  end
endmodule
